// File: rtl/iiitb_icg_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle FSM, negedge enable flop, AND gate.
// Optional macro ICG_STATS_EN builds saturating per-channel gated-cycle counters.
module iiitb_icg_ctrl #(
    parameter int NCH         = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 16,
    localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    act,
    input  logic [NCH-1:0]    force_on,
    input  logic              cg_en,
    input  logic              te,
    output logic [NCH-1:0]    cgclk,
    output logic [NCH-1:0]    gated,
    input  logic [SEL_W-1:0]  stat_sel,
    output logic [STAT_W-1:0] stat_cnt
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_GATED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(IDLE_CYCLES - 1);

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   en_req;
    logic [NCH-1:0]   en_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_ACTIVE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_ACTIVE: begin
                    cnt_d[i] = '0;
                    if (!act[i]) begin
                        if (IDLE_CYCLES > 1) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = CNT_W'(1);
                        end else begin
                            state_d[i] = ST_GATED;
                        end
                    end
                end
                ST_IDLE: begin
                    if (act[i]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LAST_IDLE) begin
                        state_d[i] = ST_GATED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_GATED: begin
                    if (act[i]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_ACTIVE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Overrides only touch the enable request; the FSM keeps tracking activity underneath.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            gated[i]  = (state_q[i] == ST_GATED);
            en_req[i] = (state_q[i] != ST_GATED) | force_on[i] | ~cg_en | te;
        end
    end

    // Enable changes only while clk is low, so the AND below cannot chop a high phase.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            en_lat <= '1;
        end else begin
            en_lat <= en_req;
        end
    end

    assign cgclk = {NCH{clk}} & en_lat;

`ifdef ICG_STATS_EN
    logic [STAT_W-1:0] stat_q [NCH];
    logic [STAT_W-1:0] stat_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!en_lat[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        stat_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(stat_sel) == i) begin
                stat_mux = stat_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt <= '0;
        end else begin
            stat_cnt <= stat_mux;
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_iiitb_icg_ctrl.sv
// Directed bench for iiitb_icg_ctrl: idle gating, wake, overrides, mid-idle reset, statistics.
module tb_iiitb_icg_ctrl;

    localparam int NCH    = 4;
    localparam int STAT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    act;
    logic [NCH-1:0]    force_on;
    logic              cg_en;
    logic              te;
    logic [NCH-1:0]    cgclk;
    logic [NCH-1:0]    gated;
    logic [1:0]        stat_sel;
    logic [STAT_W-1:0] stat_cnt;

    int checks = 0;
    int errors = 0;

    iiitb_icg_ctrl #(
        .NCH(NCH), .IDLE_CYCLES(8), .CNT_W(8), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .act(act), .force_on(force_on), .cg_en(cg_en),
        .te(te), .cgclk(cgclk), .gated(gated), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lands 2 time units into the clk high phase.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic override_run(input int kind, input int n);
        case (kind)
            0:       force_on[2] = 1'b1;
            1:       te = 1'b1;
            default: cg_en = 1'b0;
        endcase
        for (int k = 0; k < n; k++) begin
            tick();
            check_eq("ovr_cgclk2_on", 32'(cgclk[2]), 32'd1);
            check_eq("ovr_gated2", 32'(gated[2]), 32'd1);
        end
        force_on[2] = 1'b0;
        te          = 1'b0;
        cg_en       = 1'b1;
        tick();
        check_eq("ovr_cgclk2_off", 32'(cgclk[2]), 32'd0);
        check_eq("ovr_gated2_after", 32'(gated[2]), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        act      = 4'hF;
        force_on = 4'h0;
        cg_en    = 1'b1;
        te       = 1'b0;
        stat_sel = 2'd3;

        // Clocks pass through during reset.
        tick();
        tick();
        check_eq("rst_cgclk", 32'(cgclk), 32'hF);
        check_eq("rst_gated", 32'(gated), 32'h0);
        check_eq("rst_stat", 32'(stat_cnt), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("active_cgclk", 32'(cgclk), 32'hF);
            check_eq("active_gated", 32'(gated), 32'h0);
        end

        // Channel 0 idles: posedges 0..6 still ungated, GATED after posedge 7.
        act[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("idle0_gated", 32'(gated[0]), 32'd0);
            check_eq("idle0_cgclk", 32'(cgclk[0]), 32'd1);
        end
        tick();
        check_eq("k7_gated0", 32'(gated[0]), 32'd1);
        check_eq("k7_cgclk0", 32'(cgclk[0]), 32'd1);
        tick();
        check_eq("k8_cgclk0", 32'(cgclk[0]), 32'd0);
        check_eq("k8_others", 32'(cgclk[3:1]), 32'h7);
        check_eq("k8_gated", 32'(gated), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("hold_cgclk0", 32'(cgclk[0]), 32'd0);
        end

        // Wake: act sampled at posedge m, first pulse at m+1.
        act[0] = 1'b1;
        tick();
        check_eq("m_gated0", 32'(gated[0]), 32'd0);
        check_eq("m_cgclk0", 32'(cgclk[0]), 32'd0);
        tick();
        check_eq("m1_cgclk0", 32'(cgclk[0]), 32'd1);
        #2;
        check_eq("m1_cgclk0_late_high", 32'(cgclk[0]), 32'd1);
        @(negedge clk);
        #1;
        check_eq("m1_cgclk0_low", 32'(cgclk[0]), 32'd0);

        // Gate channel 2, then exercise each override.
        tick();
        act[2] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_eq("ch2_gated", 32'(gated), 32'h4);
        tick();
        check_eq("ch2_cgclk_off", 32'(cgclk), 32'hB);
        override_run(0, 3);
        override_run(1, 2);
        override_run(2, 2);

        // Reset while channel 1 idle count is 5 and channel 2 gated.
        act = 4'b1001;
        for (int k = 0; k < 5; k++) tick();
        check_eq("pre_rst_gated", 32'(gated), 32'h4);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        check_eq("midrst_cgclk", 32'(cgclk), 32'hF);
        check_eq("midrst_gated", 32'(gated), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("reidle_gated1", 32'(gated[1]), 32'd0);
        end
        tick();
        check_eq("reidle_gated", 32'(gated), 32'h6);

        // Channel 3 gated for a long stretch.
        act = 4'b0001;
        for (int k = 0; k < 300; k++) tick();
        tick();
        check_eq("long_gated", 32'(gated), 32'hE);
        check_eq("long_cgclk", 32'(cgclk), 32'h1);
`ifdef ICG_STATS_EN
        check_eq("stat_sat", 32'(stat_cnt), 32'd255);
        stat_sel = 2'd0;
        tick();
        tick();
        check_eq("stat_ch0", 32'(stat_cnt), 32'd0);
`else
        check_eq("stat_tied", 32'(stat_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
